// File: rtl/mastermind_ctrl.sv
// mastermind_ctrl: game-flow sequencer for the Mastermind datapath.
// Latches the secret at start, scores each submitted guess over 12 cycles
// (4 peg compares, then 8 per-colour minimum counts), tracks turns and
// declares win/loss.
// Optional: define MASTERMIND_REVEAL_EN to expose the secret on code_reveal
// while in WON or LOST; otherwise code_reveal is constant 0.
module mastermind_ctrl #(
  parameter int unsigned MAX_TURNS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] code_in,
  input  logic        submit,
  input  logic [11:0] guess_in,
  output logic        busy,
  output logic [3:0]  turn,
  output logic [2:0]  exact,
  output logic [2:0]  partial,
  output logic        result_valid,
  output logic        win,
  output logic        lose,
  output logic [11:0] code_reveal
);

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    SCORE_EXACT,
    SCORE_COLOR,
    REPORT,
    WON,
    LOST
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [11:0] code_q;
  logic [11:0] guess_q;
  logic [2:0]  idx;
  logic [2:0]  exact_acc;
  logic [2:0]  total_acc;
  logic [2:0]  total_next;
  logic [2:0]  col_min;
  logic        peg_match;
  logic        can_start;
  logic        take_guess;
  logic        last_turn;

  // Colour held in slot p of a packed 4-slot code.
  function automatic logic [2:0] slot(input logic [11:0] v, input logic [1:0] p);
    logic [2:0] s;
    unique case (p)
      2'd0:    s = v[2:0];
      2'd1:    s = v[5:3];
      2'd2:    s = v[8:6];
      default: s = v[11:9];
    endcase
    return s;
  endfunction

  // Number of slots of v holding colour k.
  function automatic logic [2:0] colour_count(input logic [11:0] v, input logic [2:0] k);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (slot(v, 2'(i)) == k) n = n + 3'd1;
    end
    return n;
  endfunction

  // Per-step scoring terms and flow qualifiers.
  always_comb begin
    logic [2:0] cg;
    logic [2:0] cc;
    cg         = colour_count(guess_q, idx);
    cc         = colour_count(code_q, idx);
    col_min    = (cg < cc) ? cg : cc;
    total_next = total_acc + col_min;
    peg_match  = (slot(guess_q, idx[1:0]) == slot(code_q, idx[1:0]));
    can_start  = start && (state == IDLE || state == PLAY || state == WON || state == LOST);
    take_guess = submit && !start && (state == PLAY);
    last_turn  = (turn == 4'(MAX_TURNS - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; start has priority over submit in PLAY.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:        if (start) state_next = PLAY;
      PLAY: begin
        if (start)       state_next = PLAY;
        else if (submit) state_next = SCORE_EXACT;
      end
      SCORE_EXACT: if (idx == 3'd3) state_next = SCORE_COLOR;
      SCORE_COLOR: if (idx == 3'd7) state_next = REPORT;
      REPORT: begin
        if (exact_acc == 3'd4) state_next = WON;
        else if (last_turn)    state_next = LOST;
        else                   state_next = PLAY;
      end
      WON, LOST:   if (start) state_next = PLAY;
      default:     state_next = IDLE;
    endcase
  end

  // Datapath: latched code/guess, accumulators, turn and score registers.
  // exact/partial are registered on the final colour step so they are already
  // valid during REPORT, when result_valid is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q    <= '0;
      guess_q   <= '0;
      idx       <= '0;
      exact_acc <= '0;
      total_acc <= '0;
      turn      <= '0;
      exact     <= '0;
      partial   <= '0;
    end else begin
      if (can_start) begin
        code_q  <= code_in;
        turn    <= '0;
        exact   <= '0;
        partial <= '0;
      end
      unique case (state)
        PLAY: begin
          if (take_guess) begin
            guess_q   <= guess_in;
            idx       <= '0;
            exact_acc <= '0;
            total_acc <= '0;
          end
        end
        SCORE_EXACT: begin
          exact_acc <= exact_acc + {2'b00, peg_match};
          idx       <= (idx == 3'd3) ? 3'd0 : idx + 3'd1;
        end
        SCORE_COLOR: begin
          total_acc <= total_next;
          idx       <= idx + 3'd1;
          if (idx == 3'd7) begin
            exact   <= exact_acc;
            partial <= total_next - exact_acc;
          end
        end
        REPORT: begin
          if (exact_acc != 3'd4 && !last_turn) turn <= turn + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state == SCORE_EXACT) || (state == SCORE_COLOR) || (state == REPORT);
  assign result_valid = (state == REPORT);
  assign win          = (state == WON);
  assign lose         = (state == LOST);

`ifdef MASTERMIND_REVEAL_EN
  assign code_reveal = (state == WON || state == LOST) ? code_q : '0;
`else
  assign code_reveal = '0;
`endif

endmodule
